// File: rtl/fb_arbiter_if.sv
// Writer request channel and framebuffer RAM bus owned by fb_arbiter.
// wr_*: a transfer happens on each rising edge where wr_valid && wr_ready; the writer holds addr/data stable while valid.
interface fb_arbiter_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [16:0] wr_addr;
  logic [11:0] wr_data;
  logic        mem_en;
  logic        mem_we;
  logic [16:0] mem_addr;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;

  modport slave (
    input  wr_valid, wr_addr, wr_data, mem_rdata,
    output wr_ready, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output wr_valid, wr_addr, wr_data, mem_rdata,
    input  wr_ready, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: display fetch has absolute priority, queued writes
// fill the remaining slots. Pixels leave 2 clocks after the fetch decision, each word shown twice.
module fb_arbiter #(
  parameter int H_SRC    = 320,
  parameter int V_SRC    = 240,
  parameter int WQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        visible,
  fb_arbiter_if.slave bus,
  output logic [11:0] pixel_data,
  output logic        pixel_valid,
  output logic        wr_oor
);

  localparam int          PW      = $clog2(WQ_DEPTH);
  localparam logic [16:0] NUM_PIX = 17'(H_SRC * V_SRC);

  logic [16:0]   q_addr [WQ_DEPTH];
  logic [11:0]   q_data [WQ_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          ready_en;
  logic          full, empty, push, keep, pop, disp;
  logic [16:0]   y_src, x_src, disp_addr;
  logic          vis_d1, vis_d2, rd_live;
  logic [11:0]   pix_hold, pix_word;

  always_comb begin
    full         = (count == (PW+1)'(WQ_DEPTH));
    empty        = (count == '0);
    bus.wr_ready = ready_en && !full;
    push         = bus.wr_valid && bus.wr_ready;
    keep         = push && (bus.wr_addr < NUM_PIX);
    disp         = visible && !h_cnt[0];
    pop          = !disp && !empty;
    // Source is 2x downscaled; y*320 as (y<<8)+(y<<6) keeps the multiply off DSP blocks.
    y_src        = {7'd0, v_cnt} >> 1;
    x_src        = {7'd0, h_cnt} >> 1;
    disp_addr    = (y_src << 8) + (y_src << 6) + x_src;
  end

  // Queue storage carries no reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (keep) begin
      q_addr[wr_ptr] <= bus.wr_addr;
      q_data[wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_en      <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      wr_oor        <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      vis_d1        <= 1'b0;
      vis_d2        <= 1'b0;
      rd_live       <= 1'b0;
      pix_hold      <= '0;
    end else begin
      ready_en <= 1'b1;
      if (keep) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({keep, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !keep) wr_oor <= 1'b1;

      if (disp) begin
        bus.mem_en    <= 1'b1;
        bus.mem_we    <= 1'b0;
        bus.mem_addr  <= disp_addr;
        bus.mem_wdata <= '0;
      end else if (pop) begin
        bus.mem_en    <= 1'b1;
        bus.mem_we    <= 1'b1;
        bus.mem_addr  <= q_addr[rd_ptr];
        bus.mem_wdata <= q_data[rd_ptr];
      end else begin
        bus.mem_en    <= 1'b0;
        bus.mem_we    <= 1'b0;
        bus.mem_addr  <= '0;
        bus.mem_wdata <= '0;
      end

      vis_d1  <= visible;
      vis_d2  <= vis_d1;
      // rd_live marks the cycle mem_rdata carries a fresh fetch; hold it for the repeat pixel.
      rd_live <= bus.mem_en && !bus.mem_we;
      if (rd_live) pix_hold <= bus.mem_rdata;
    end
  end

  always_comb begin
    pix_word    = rd_live ? bus.mem_rdata : pix_hold;
    pixel_data  = vis_d2 ? pix_word : 12'd0;
    pixel_valid = vis_d2;
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter: a reference slot/queue model checks every cycle,
// plus explicit checks for pixel values, bandwidth, out-of-range drops and mid-run reset.
`timescale 1ns/1ps
module tb_fb_arbiter;
  localparam int W = 29;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  h_cnt = '0;
  logic [9:0]  v_cnt = '0;
  logic        visible = 1'b0;
  logic [11:0] pixel_data;
  logic        pixel_valid;
  logic        wr_oor;

  fb_arbiter_if bus();

  logic [W-1:0] exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic oor_exp = 1'b0;
  logic vis_last = 1'b0;
  logic ready_armed = 1'b0;
  logic ready_low = 1'b0;
  int   n_written = 0;
  int   we_run = 0;
  int   we_run_max = 0;
  int   issued;
  bit   acc;

  // clock / reset
  always #20 clk = ~clk;

  fb_arbiter #(.H_SRC(320), .V_SRC(240), .WQ_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .visible(visible),
    .bus(bus), .pixel_data(pixel_data), .pixel_valid(pixel_valid), .wr_oor(wr_oor)
  );

  // RAM model: a read returns the low 12 bits of its address one cycle later
  always @(posedge clk)
    if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= bus.mem_addr[11:0];

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // one clock: predict the slot from current inputs, tick, compare against the model
  task automatic cycle(output bit accepted);
    bit           exp_disp, exp_wr, prev_vis;
    logic [16:0]  exp_addr;
    logic [W-1:0] head;
    exp_disp = visible && !h_cnt[0];
    exp_addr = 17'(v_cnt >> 1) * 17'd320 + 17'(h_cnt >> 1);
    exp_wr   = !exp_disp && (exp_q.size() != 0);
    chk("wr_ready", 32'(bus.wr_ready), 32'(ready_armed && (exp_q.size() < 4)));
    accepted = bus.wr_valid && bus.wr_ready;
    if (!bus.wr_ready) ready_low = 1'b1;
    if (exp_wr) head = exp_q.pop_front();
    else        head = '0;
    if (accepted) begin
      if (bus.wr_addr < 17'd76800) exp_q.push_back({bus.wr_addr, bus.wr_data});
      else                         oor_exp = 1'b1;
    end
    prev_vis = vis_last;
    vis_last = visible;
    @(posedge clk); #1;
    ready_armed = 1'b1;
    if (exp_disp) begin
      chk("disp_en_we", 32'({bus.mem_en, bus.mem_we}), 32'(2'b10));
      chk("disp_addr", 32'(bus.mem_addr), 32'(exp_addr));
    end else if (exp_wr) begin
      chk("wr_en_we", 32'({bus.mem_en, bus.mem_we}), 32'(2'b11));
      chk("wr_mem_addr", 32'(bus.mem_addr), 32'(head[28:12]));
      chk("wr_mem_data", 32'(bus.mem_wdata), 32'(head[11:0]));
      n_written++;
    end else begin
      chk("idle_en", 32'(bus.mem_en), 32'(0));
    end
    if (bus.mem_we) begin
      we_run++;
      if (we_run > we_run_max) we_run_max = we_run;
    end else begin
      we_run = 0;
    end
    chk("wr_oor", 32'(wr_oor), 32'(oor_exp));
    chk("pixel_valid", 32'(pixel_valid), 32'(prev_vis));
    if (!prev_vis) chk("pixel_blank", 32'(pixel_data), 32'(0));
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;

    // reset release in blanking
    v_cnt = 10'd490; h_cnt = 10'd0; visible = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_en", 32'(bus.mem_en), 32'(0));
    chk("rst_mem_we", 32'(bus.mem_we), 32'(0));
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'(0));
    chk("rst_pixel_valid", 32'(pixel_valid), 32'(0));
    chk("rst_pixel_data", 32'(pixel_data), 32'(0));
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("release_wr_ready", 32'(bus.wr_ready), 32'(0));
    cycle(acc);
    chk("ready_after_rst", 32'(bus.wr_ready), 32'(1));
    repeat (3) cycle(acc);

    // visible line 10 with 8 streamed writes
    v_cnt = 10'd10; issued = 0; n_written = 0; ready_low = 1'b0;
    for (int h = 0; h < 642; h++) begin
      h_cnt        = 10'(h);
      visible      = (h < 640);
      bus.wr_valid = (h >= 20) && (issued < 8);
      bus.wr_addr  = 17'(50000 + issued * 7);
      bus.wr_data  = 12'(12'h100 + issued);
      cycle(acc);
      if (acc) issued++;
      if (h >= 1 && h <= 640)
        chk("pixel_data", 32'(pixel_data), 32'(1600 + ((h + 1) >> 1) - 1));
    end
    bus.wr_valid = 1'b0;
    chk("vis_writes", 32'(n_written), 32'(8));
    chk("vis_ready_drop", 32'(ready_low), 32'(1));
    chk("vis_q_drained", 32'(exp_q.size()), 32'(0));

    // blanking burst of 6 writes
    v_cnt = 10'd500; visible = 1'b0; issued = 0; n_written = 0;
    ready_low = 1'b0; we_run = 0; we_run_max = 0;
    for (int h = 0; h < 12; h++) begin
      h_cnt        = 10'(h);
      bus.wr_valid = (issued < 6);
      bus.wr_addr  = 17'(1000 + issued * 3);
      bus.wr_data  = 12'(12'hA00 + issued);
      cycle(acc);
      if (acc) issued++;
    end
    bus.wr_valid = 1'b0;
    chk("blank_writes", 32'(n_written), 32'(6));
    chk("blank_ready_drop", 32'(ready_low), 32'(0));
    chk("blank_burst", 32'(we_run_max), 32'(6));

    // out-of-range and last-in-range address
    n_written = 0;
    chk("oor_before", 32'(wr_oor), 32'(0));
    bus.wr_valid = 1'b1; bus.wr_addr = 17'd76800; bus.wr_data = 12'hFFF;
    cycle(acc);
    chk("oor_accepted", 32'(acc), 32'(1));
    bus.wr_addr = 17'd76799; bus.wr_data = 12'h5A5;
    cycle(acc);
    chk("edge_accepted", 32'(acc), 32'(1));
    bus.wr_valid = 1'b0;
    repeat (6) cycle(acc);
    chk("oor_sticky", 32'(wr_oor), 32'(1));
    chk("edge_written", 32'(n_written), 32'(1));

    // reset with 3 queued writes and live pixels
    v_cnt = 10'd20; h_cnt = 10'd0; visible = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 17'(2000 + i);
      bus.wr_data  = 12'(i + 1);
      cycle(acc);
    end
    bus.wr_valid = 1'b0;
    cycle(acc);
    cycle(acc);
    chk("pre_rst_queue", 32'(exp_q.size()), 32'(3));
    chk("pre_rst_pixel_valid", 32'(pixel_valid), 32'(1));
    #5 rst = 1'b0;
    #1;
    chk("mid_rst_mem_en", 32'(bus.mem_en), 32'(0));
    chk("mid_rst_mem_we", 32'(bus.mem_we), 32'(0));
    chk("mid_rst_mem_addr", 32'(bus.mem_addr), 32'(0));
    chk("mid_rst_mem_wdata", 32'(bus.mem_wdata), 32'(0));
    chk("mid_rst_pixel_data", 32'(pixel_data), 32'(0));
    chk("mid_rst_pixel_valid", 32'(pixel_valid), 32'(0));
    chk("mid_rst_wr_oor", 32'(wr_oor), 32'(0));
    chk("mid_rst_wr_ready", 32'(bus.wr_ready), 32'(0));
    exp_q.delete();
    oor_exp = 1'b0; vis_last = 1'b0; ready_armed = 1'b0;
    visible = 1'b0; v_cnt = 10'd490; h_cnt = 10'd0;
    @(negedge clk);
    rst = 1'b1;
    n_written = 0;
    repeat (10) cycle(acc);
    chk("post_rst_writes", 32'(n_written), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
- Owns the single-port 320x240 RGB444 framebuffer RAM (76800 words, 1-cycle synchronous read).
- Shares the RAM between two users:
  - the VGA display fetch path, which has fixed timing and absolute priority;
  - a game-logic writer, served through a valid/ready interface and a small write queue.
- Consumes h_cnt/v_cnt/visible from vga_controller.
- Produces a pixel stream for image_display, delayed by a fixed 2 clocks.

Parameters:
- H_SRC, 320, source image width in words.
- V_SRC, 240, source image height in lines.
- WQ_DEPTH, 4, write-queue depth in entries (power of 2, >=2).

Ports:
- clk  input  1  25 MHz pixel clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- h_cnt  input  10  horizontal counter from vga_controller.
- v_cnt  input  10  vertical counter from vga_controller.
- visible  input  1  active-video flag from vga_controller.
- wr_valid  input  1  writer request valid.
- wr_ready  output  1  queue can accept an entry.
- wr_addr  input  17  linear pixel address, y*320+x.
- wr_data  input  12  RGB444 data.
- mem_en  output  1  RAM enable.
- mem_we  output  1  RAM write enable.
- mem_addr  output  17  RAM address.
- mem_wdata  output  12  RAM write data.
- mem_rdata  input  12  RAM read data, valid 1 cycle after a read with mem_en=1 and mem_we=0.
- pixel_data  output  12  RGB444 pixel for image_display.
- pixel_valid  output  1  visible delayed by 2 clocks.
- wr_oor  output  1  sticky flag: an out-of-range write was dropped.

Behaviour:
- Reset state (rst low, asynchronous):
  - mem_en, mem_we, mem_addr, mem_wdata = 0.
  - pixel_data = 0, pixel_valid = 0, wr_oor = 0.
  - Queue empty, wr_ready = 0.
  - The cycle after rst deasserts, wr_ready = 1.
- Slot selection is made each cycle from the current inputs:
  - DISP slot: visible=1 and h_cnt[0]=0.
    - Read with mem_en=1, mem_we=0.
    - mem_addr = (v_cnt>>1)*320 + (h_cnt>>1).
    - Multiply by shift-add (y<<8)+(y<<6); no DSP multiplier.
  - WR slot: not a DISP slot and the queue is non-empty.
    - Pop the head entry: mem_en=1, mem_we=1, with its addr and data.
  - IDLE: neither condition holds; mem_en=0, mem_we=0.
  - mem_* are registered outputs: the slot decided in cycle t drives the RAM in cycle t+1. All display timing below is counted from the decision cycle.
- Write bandwidth:
  - During visible: at most one write per 2 clocks.
  - During blanking: one write per clock.
  - The display is never delayed or skipped.
- Display pipeline:
  - A fetch decided at h_cnt=2k produces pixel_data during the cycles where h_cnt = 2k+2 and 2k+3. Latency is 2 clocks, and each word is shown twice.
  - Each source line is fetched again on both display lines 2y and 2y+1. There is no line buffer.
  - pixel_valid is visible delayed by 2 clocks.
  - pixel_data = 0 whenever the delayed visible is 0.
  - image_display delays hsync/vsync by 2 clocks to match.
- Write queue (FIFO, WQ_DEPTH entries):
  - Push when wr_valid and wr_ready are both 1.
  - wr_ready = !full.
  - No fall-through: an entry pushed in cycle t is eligible to pop no earlier than cycle t+1.
  - Simultaneous push and pop with the queue non-empty and not full: count is unchanged.
  - When full, wr_ready=0 and wr_valid is ignored.
  - Pointers wrap modulo WQ_DEPTH.
- Out of range:
  - A write with wr_addr >= 76800 is still accepted (it consumes the handshake) but is not queued.
  - The dropped write sets wr_oor=1, which stays set until reset.
- Reset mid-operation:
  - Queued writes are discarded.
  - Any RAM access in flight is abandoned.
  - The pixel pipeline clears to 0.

Test Plan:
- Reset release in blanking (v_cnt=490) → wr_ready=1 one cycle later; mem_en=0; pixel_valid=0; pixel_data=0.
- Visible line v_cnt=10, h_cnt=0..639 → one read on every even h_cnt, at mem_addr=5*320+h/2 (1600..1919); with mem_rdata=addr[11:0], pixel_data at h_cnt=2k+2 and 2k+3 = (1600+k)[11:0].
- Writer streams 8 writes back-to-back during the visible region → queue fills after 4; wr_ready drops; each write lands only on a WR slot (odd h_cnt); all 8 are written in order; the DISP addresses are unperturbed.
- 6 writes issued during blanking → one RAM write per clock after the first push; wr_ready never drops; mem_addr and mem_wdata match in order.
- wr_addr=76800 with wr_valid=1 → accepted, no mem_we pulse, wr_oor=1 and held.
- rst pulled low with the queue at 3 entries and pixel_valid=1 → all outputs 0 immediately; after release, no stale writes reach the RAM.
